// File: rtl/pc_chk_pkg.sv
// Shared types for the PC flow checker: FSM states and per-sample classification codes.
// Also used by the bench and the debug UART dump.
package pc_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_SEQ   = 2'd0,
        CLS_REDIR = 2'd1,
        CLS_RULE  = 2'd2,
        CLS_ERR   = 2'd3
    } err_class_t;

    // Sequential flow wins over a redirect, and a redirect wins over a rule hit.
    function automatic err_class_t classify(input logic seq, input logic redir, input logic hit);
        if (seq)
            return CLS_SEQ;
        else if (redir)
            return CLS_REDIR;
        else if (hit)
            return CLS_RULE;
        else
            return CLS_ERR;
    endfunction

endpackage

// File: rtl/pc_rule_table.sv
// Whitelist of allowed from->to jump pairs with a single write port.
// The match is purely combinational on the registered table.
module pc_rule_table
    import pc_chk_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_RULES = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    input  logic [XLEN-1:0]  from,
    input  logic [XLEN-1:0]  to,
    input  logic [XLEN-1:0]  last_pc,
    input  logic [XLEN-1:0]  pc,
    output logic             hit
);

    logic [NUM_RULES-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RULES; gi++) begin : g_rule
            logic            en_reg;
            logic [XLEN-1:0] from_reg;
            logic [XLEN-1:0] to_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    en_reg   <= 1'b0;
                    from_reg <= '0;
                    to_reg   <= '0;
                end else if (we && (idx == IDX_W'(gi))) begin
                    en_reg   <= en;
                    from_reg <= from;
                    to_reg   <= to;
                end
            end

            assign match[gi] = en_reg && (from_reg == last_pc) && (to_reg == pc);
        end
    endgenerate

    assign hit = |match;

endmodule

// File: rtl/pc_flow_checker.sv
// Watches the PC stream and flags every transition that is neither sequential,
// a core-announced redirect, nor a whitelisted jump. Counts samples/errors and logs the first error.
module pc_flow_checker
    import pc_chk_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int unsigned STRIDE    = 4,
    parameter int          NUM_RULES = 4,
    parameter int          CNT_W     = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              pc_valid_i,
    input  logic [XLEN-1:0]                                   pc_i,
    input  logic                                              redirect_i,
    input  logic                                              rule_we_i,
    input  logic [((NUM_RULES > 1) ? $clog2(NUM_RULES) : 1)-1:0] rule_idx_i,
    input  logic                                              rule_en_i,
    input  logic [XLEN-1:0]                                   rule_from_i,
    input  logic [XLEN-1:0]                                   rule_to_i,
    input  logic [CNT_W-1:0]                                  budget_i,
    input  logic                                              clear_i,
    output logic [CNT_W-1:0]                                  sample_cnt_o,
    output logic [CNT_W-1:0]                                  err_cnt_o,
    output logic                                              err_o,
    output logic [XLEN-1:0]                                   first_err_from_o,
    output logic [XLEN-1:0]                                   first_err_to_o,
    output logic                                              first_err_vld_o,
    output logic                                              done_o
);

    localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

    state_t          state_reg;
    logic [XLEN-1:0] last_pc_reg;
    logic [CNT_W-1:0] sample_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic            err_reg;
    logic [XLEN-1:0] first_from_reg;
    logic [XLEN-1:0] first_to_reg;
    logic            first_vld_reg;
    logic            done_reg;

    logic            hit;
    err_class_t      cls;
    logic [CNT_W-1:0] cnt_next;
    logic            budget_hit;

    pc_rule_table #(
        .XLEN      (XLEN),
        .NUM_RULES (NUM_RULES),
        .IDX_W     (IDX_W)
    ) u_rules (
        .clk     (clk),
        .rst     (rst),
        .we      (rule_we_i),
        .idx     (rule_idx_i),
        .en      (rule_en_i),
        .from    (rule_from_i),
        .to      (rule_to_i),
        .last_pc (last_pc_reg),
        .pc      (pc_i),
        .hit     (hit)
    );

    always_comb begin
        cls = classify(pc_i == (last_pc_reg + XLEN'(STRIDE)), redirect_i, hit);
        if (state_reg == ST_IDLE)
            cnt_next = CNT_W'(1);
        else if (&sample_cnt_reg)
            cnt_next = sample_cnt_reg;
        else
            cnt_next = sample_cnt_reg + CNT_W'(1);
        budget_hit = (budget_i != '0) && (cnt_next == budget_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_pc_reg    <= '0;
            sample_cnt_reg <= '0;
            err_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            first_from_reg <= '0;
            first_to_reg   <= '0;
            first_vld_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            // A clear drops any coincident sample; the rule table is untouched.
            if (clear_i) begin
                state_reg      <= ST_IDLE;
                last_pc_reg    <= '0;
                sample_cnt_reg <= '0;
                err_cnt_reg    <= '0;
                first_from_reg <= '0;
                first_to_reg   <= '0;
                first_vld_reg  <= 1'b0;
                done_reg       <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (pc_valid_i) begin
                            last_pc_reg    <= pc_i;
                            sample_cnt_reg <= cnt_next;
                            state_reg      <= budget_hit ? ST_DONE : ST_RUN;
                            done_reg       <= budget_hit;
                        end
                    end
                    ST_RUN: begin
                        if (pc_valid_i) begin
                            last_pc_reg    <= pc_i;
                            sample_cnt_reg <= cnt_next;
                            if (cls == CLS_ERR) begin
                                err_reg <= 1'b1;
                                if (!(&err_cnt_reg))
                                    err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                                if (!first_vld_reg) begin
                                    first_from_reg <= last_pc_reg;
                                    first_to_reg   <= pc_i;
                                    first_vld_reg  <= 1'b1;
                                end
                            end
                            if (budget_hit) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= ST_DONE;
                    end
                endcase
            end
        end
    end

    assign sample_cnt_o     = sample_cnt_reg;
    assign err_cnt_o        = err_cnt_reg;
    assign err_o            = err_reg;
    assign first_err_from_o = first_from_reg;
    assign first_err_to_o   = first_to_reg;
    assign first_err_vld_o  = first_vld_reg;
    assign done_o           = done_reg;

endmodule

// File: tb/tb_pc_flow_checker.sv
// Directed scenarios plus a randomized run against a behavioural model of the PC flow rules.
module tb_pc_flow_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        redirect;
    logic        rule_we;
    logic [1:0]  rule_idx;
    logic        rule_en;
    logic [31:0] rule_from;
    logic [31:0] rule_to;
    logic [15:0] budget;
    logic        clear;
    logic [15:0] sample_cnt;
    logic [15:0] err_cnt;
    logic        err;
    logic [31:0] first_from;
    logic [31:0] first_to;
    logic        first_vld;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses;

    // Reference model state
    bit          m_started, m_done, m_err, m_fvld;
    logic [31:0] m_last, m_ffrom, m_fto;
    int unsigned m_cnt, m_errs;
    bit          m_ren [4];
    logic [31:0] m_rfrom [4];
    logic [31:0] m_rto [4];

    always #5 clk = ~clk;

    pc_flow_checker dut (
        .clk              (clk),
        .rst              (rst),
        .pc_valid_i       (pc_valid),
        .pc_i             (pc),
        .redirect_i       (redirect),
        .rule_we_i        (rule_we),
        .rule_idx_i       (rule_idx),
        .rule_en_i        (rule_en),
        .rule_from_i      (rule_from),
        .rule_to_i        (rule_to),
        .budget_i         (budget),
        .clear_i          (clear),
        .sample_cnt_o     (sample_cnt),
        .err_cnt_o        (err_cnt),
        .err_o            (err),
        .first_err_from_o (first_from),
        .first_err_to_o   (first_to),
        .first_err_vld_o  (first_vld),
        .done_o           (done)
    );

    task automatic drive(input logic v, input logic [31:0] p, input logic r);
        pc_valid = v;
        pc       = p;
        redirect = r;
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
        redirect = 1'b0;
        if (err === 1'b1) err_pulses++;
        $display("sample v=%0b pc=%08h redir=%0b -> cnt=%0d errs=%0d err=%0b done=%0b",
                 v, p, r, sample_cnt, err_cnt, err, done);
    endtask

    task automatic write_rule(input logic [1:0] i, input logic e, input logic [31:0] f, input logic [31:0] t);
        rule_we = 1'b1; rule_idx = i; rule_en = e; rule_from = f; rule_to = t;
        @(posedge clk);
        #1;
        rule_we = 1'b0;
        $display("rule[%0d] en=%0b %08h->%08h", i, e, f, t);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        err_pulses = 0;
    endtask

    task automatic model_reset();
        m_started = 0; m_done = 0; m_err = 0; m_fvld = 0;
        m_last = '0; m_ffrom = '0; m_fto = '0; m_cnt = 0; m_errs = 0;
        for (int i = 0; i < 4; i++) begin
            m_ren[i] = 0; m_rfrom[i] = '0; m_rto[i] = '0;
        end
    endtask

    // Applies the flow rules to the inputs currently presented; rule writes land afterwards.
    task automatic model_step();
        bit ok;
        m_err = 0;
        if (clear) begin
            m_started = 0; m_done = 0; m_fvld = 0;
            m_last = '0; m_ffrom = '0; m_fto = '0; m_cnt = 0; m_errs = 0;
        end else if (pc_valid && !m_done) begin
            if (!m_started) begin
                m_started = 1;
                m_cnt = 1;
            end else begin
                if (m_cnt < 65535) m_cnt++;
                ok = (pc == m_last + 32'd4) || redirect;
                for (int i = 0; i < 4; i++)
                    if (m_ren[i] && m_rfrom[i] == m_last && m_rto[i] == pc) ok = 1;
                if (!ok) begin
                    m_err = 1;
                    if (m_errs < 65535) m_errs++;
                    if (!m_fvld) begin
                        m_fvld = 1; m_ffrom = m_last; m_fto = pc;
                    end
                end
            end
            m_last = pc;
            if (budget != 0 && m_cnt == int'(budget)) m_done = 1;
        end
        if (rule_we) begin
            m_ren[rule_idx] = rule_en; m_rfrom[rule_idx] = rule_from; m_rto[rule_idx] = rule_to;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", sample_cnt); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_errs: got %0d expected 0", err_cnt); end
        n_checks++; if (err !== 1'b0 || done !== 1'b0 || first_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got err=%b done=%b vld=%b expected 0 0 0", err, done, first_vld); end
        n_checks++; if (first_from !== 32'd0 || first_to !== 32'd0) begin
            n_fail++; $display("FAIL reset_log: got %h->%h expected 0->0", first_from, first_to); end
    endtask

    task automatic test_whitelist();
        budget = 16'd0;
        do_clear();
        write_rule(2'd0, 1'b1, 32'h28, 32'h00);
        for (int i = 0; i <= 10; i++) drive(1'b1, 32'(i * 4), 1'b0);
        drive(1'b1, 32'h00, 1'b0);
        n_checks++; if (sample_cnt !== 16'd12) begin n_fail++; $display("FAIL whitelist_cnt: got %0d expected 12", sample_cnt); end
        n_checks++; if (err_cnt !== 16'd0 || err_pulses != 0) begin
            n_fail++; $display("FAIL whitelist_errs: got %0d (pulses %0d) expected 0", err_cnt, err_pulses); end
    endtask

    task automatic test_no_rule();
        do_clear();
        write_rule(2'd0, 1'b0, 32'h28, 32'h00);
        for (int i = 0; i <= 10; i++) drive(1'b1, 32'(i * 4), 1'b0);
        drive(1'b1, 32'h00, 1'b0);
        n_checks++; if (err_pulses != 1) begin n_fail++; $display("FAIL norule_pulses: got %0d expected 1", err_pulses); end
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL norule_errs: got %0d expected 1", err_cnt); end
        n_checks++; if (first_from !== 32'h28 || first_to !== 32'h00 || first_vld !== 1'b1) begin
            n_fail++; $display("FAIL norule_log: got %h->%h vld=%b expected 28->0 vld=1", first_from, first_to, first_vld); end
    endtask

    task automatic test_redirect();
        do_clear();
        drive(1'b1, 32'h10, 1'b0);
        drive(1'b1, 32'h80, 1'b1);
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL redirect_ok: got %0d expected 0", err_cnt); end
        drive(1'b1, 32'h88, 1'b0);
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL redirect_err: got %0d expected 1", err_cnt); end
        n_checks++; if (first_from !== 32'h80 || first_to !== 32'h88) begin
            n_fail++; $display("FAIL redirect_log: got %h->%h expected 80->88", first_from, first_to); end
    endtask

    task automatic test_budget();
        budget = 16'd5;
        do_clear();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(32'h1000 + i * 4), 1'b0);
            if (i == 4) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL budget_early: got done=%b expected 0", done); end
            end
            if (i == 5) begin
                n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL budget_done: got done=%b expected 1", done); end
            end
        end
        n_checks++; if (sample_cnt !== 16'd5 || done !== 1'b1) begin
            n_fail++; $display("FAIL budget_hold: got cnt=%0d done=%b expected 5 1", sample_cnt, done); end
        budget = 16'd0;
        do_clear();
    endtask

    task automatic test_wrap_clear();
        do_clear();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0);
        drive(1'b1, 32'h0000_0000, 1'b0);
        n_checks++; if (err_cnt !== 16'd0 || sample_cnt !== 16'd2) begin
            n_fail++; $display("FAIL wrap: got cnt=%0d errs=%0d expected 2 0", sample_cnt, err_cnt); end
        clear = 1'b1;
        drive(1'b1, 32'h0000_0004, 1'b0);
        clear = 1'b0;
        n_checks++; if (sample_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clear_drop: got cnt=%0d errs=%0d expected 0 0", sample_cnt, err_cnt); end
        drive(1'b1, 32'h0000_0400, 1'b0);
        n_checks++; if (sample_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clear_idle: got cnt=%0d errs=%0d expected 1 0", sample_cnt, err_cnt); end
    endtask

    task automatic test_rst_mid_run();
        do_clear();
        write_rule(2'd0, 1'b1, 32'h28, 32'h00);
        drive(1'b1, 32'h28, 1'b0);
        drive(1'b1, 32'h00, 1'b0);
        drive(1'b1, 32'h100, 1'b0);
        drive(1'b1, 32'h200, 1'b0);
        drive(1'b1, 32'h300, 1'b0);
        n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL rst_pre_errs: got %0d expected 3", err_cnt); end
        rst = 1'b1;
        drive(1'b1, 32'h304, 1'b0);
        rst = 1'b0;
        test_reset();
        err_pulses = 0;
        drive(1'b1, 32'h28, 1'b0);
        drive(1'b1, 32'h00, 1'b0);
        n_checks++; if (err_cnt !== 16'd1 || err_pulses != 1) begin
            n_fail++; $display("FAIL rst_rule_cleared: got errs=%0d pulses=%0d expected 1 1", err_cnt, err_pulses); end
    endtask

    task automatic test_random();
        int unsigned r, k;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            redirect = 1'b0;
            if (r < 55) begin
                pc = m_last + 32'd4;
            end else if (r < 70) begin
                k = $urandom_range(0, 3);
                pc = (m_last == m_rfrom[k]) ? m_rto[k] : m_rfrom[k];
            end else if (r < 80) begin
                pc = 32'($urandom_range(0, 63)) * 32'd4;
                redirect = 1'b1;
            end else begin
                pc = 32'($urandom_range(0, 63)) * 32'd4;
            end
            pc_valid  = ($urandom_range(0, 9) != 0);
            rule_we   = ($urandom_range(0, 9) == 0);
            rule_idx  = 2'($urandom_range(0, 3));
            rule_en   = 1'($urandom_range(0, 1));
            rule_from = 32'($urandom_range(0, 15)) * 32'd16;
            rule_to   = 32'($urandom_range(0, 15)) * 32'd16;
            clear     = ($urandom_range(0, 119) == 0);
            if (clear) budget = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(10, 60));
            model_step();
            @(posedge clk);
            #1;
            $display("rand %0d v=%0b pc=%08h redir=%0b clr=%0b -> cnt=%0d errs=%0d err=%0b done=%0b",
                     i, pc_valid, pc, redirect, clear, sample_cnt, err_cnt, err, done);
            n_checks++; if (sample_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, sample_cnt, m_cnt); end
            n_checks++; if (err_cnt !== 16'(m_errs)) begin n_fail++; $display("FAIL rand_errs[%0d]: got %0d expected %0d", i, err_cnt, m_errs); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", i, err, m_err); end
            n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done[%0d]: got %b expected %b", i, done, m_done); end
            n_checks++; if (first_vld !== m_fvld || first_from !== m_ffrom || first_to !== m_fto) begin
                n_fail++; $display("FAIL rand_log[%0d]: got %b %h->%h expected %b %h->%h",
                                   i, first_vld, first_from, first_to, m_fvld, m_ffrom, m_fto); end
            pc_valid = 1'b0; rule_we = 1'b0; clear = 1'b0; redirect = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; pc_valid = 1'b0; pc = '0; redirect = 1'b0;
        rule_we = 1'b0; rule_idx = '0; rule_en = 1'b0; rule_from = '0; rule_to = '0;
        budget = '0; clear = 1'b0; err_pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_whitelist();
        test_no_rule();
        test_redirect();
        test_budget();
        test_wrap_clear();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_flow_checker.md
# pc_flow_checker

Synthesizable, parametrised program-counter flow checker that sits beside `core` and watches the fetch/retire PC stream. It classifies each valid PC sample against the previous one as sequential (+STRIDE), a core-announced redirect, a whitelisted jump pair, or an error. It counts samples and errors, latches the first offending transition, and asserts `done_o` after a programmable sample budget. It replaces ad-hoc bench-side PC printing with a block usable in simulation and on FPGA.

## Interface
- `XLEN`, 32, PC width
- `STRIDE`, 4, expected sequential increment (bytes)
- `NUM_RULES`, 4, whitelist entries (from→to jump pairs), ≥1
- `CNT_W`, 16, width of sample and error counters
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pc_valid_i`  in  1  PC sample strobe
- `pc_i`  in  XLEN  sampled PC
- `redirect_i`  in  1  core flags this sample as a legitimate branch/jump/trap target
- `rule_we_i`  in  1  whitelist write strobe
- `rule_idx_i`  in  $clog2(NUM_RULES) (min 1)  entry index
- `rule_en_i`  in  1  entry enable
- `rule_from_i` / `rule_to_i`  in  XLEN  jump source / target
- `budget_i`  in  CNT_W  samples to check before DONE; 0 = unlimited
- `clear_i`  in  1  return to IDLE, zero counters, clear log; rules retained
- `sample_cnt_o`  out  CNT_W  valid samples accepted
- `err_cnt_o`  out  CNT_W  errors detected
- `err_o`  out  1  one-cycle pulse per error
- `first_err_from_o` / `first_err_to_o`  out  XLEN  first offending transition
- `first_err_vld_o`  out  1  first-error registers hold data
- `done_o`  out  1  budget reached (level)

## Operation
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: the first `pc_valid_i` stores `pc_i` as `last_pc`, sets `sample_cnt` to 1, performs no check, and moves to RUN.
- RUN: each `pc_valid_i` increments `sample_cnt` and classifies the sample as follows.
  - OK if `pc_i == last_pc + STRIDE` (modulo 2^XLEN; wrap from 0xFFFFFFFC to 0 is sequential).
  - OK if `redirect_i`.
  - OK if any enabled rule has `from == last_pc` and `to == pc_i`.
  - Otherwise an error: `err_cnt` increments (saturating at all-ones), `err_o` pulses, and the first error loads `first_err_*` and sets `first_err_vld_o`.
  - `last_pc` takes `pc_i` in every case.
- DONE: entered when `budget_i != 0` and the post-increment `sample_cnt == budget_i`. Samples are ignored and counters frozen until `clear_i` or `rst`.
- `sample_cnt` saturates at all-ones. With budget 0 the block stays in RUN.
- Rule writes are accepted in any state. A rule written in the same cycle as a sample is not visible to that sample; the old table is used.
- `clear_i` has priority over a coincident sample: the sample is dropped.
- `rst` mid-run aborts the run and clears all state, including every rule enable.

## Timing
- Outputs are registered. A sample at edge N is reflected in `sample_cnt_o`, `err_cnt_o`, `err_o`, `first_err_*` and `done_o` after edge N, i.e. one-cycle latency.
- Back-to-back samples are supported every cycle with no stalls.
- Reset values:
  - state IDLE
  - all counters 0
  - `err_o` 0, `done_o` 0, `first_err_vld_o` 0
  - `first_err_from_o` and `first_err_to_o` 0
  - `last_pc` 0
  - all rules disabled
- The rule match is a single-cycle parallel compare of NUM_RULES × 2 XLEN comparators. No pipelining at NUM_RULES ≤ 8.

## Structure
- Shared package `pc_chk_pkg` holds the state enum (IDLE/RUN/DONE) and the error-class codes (SEQ, REDIR, RULE, ERR), reused by the bench and the debug UART dump.
- One sub-module: `pc_rule_table`, the NUM_RULES register file with its write port and combinational match output `hit`.
- FSM, counters and error log live in the top module.

## Test plan
- PCs 0x00,0x04,…,0x28 then 0x00, with rule0 = (0x28→0x00) enabled and budget 0: `err_cnt_o` 0, `sample_cnt_o` 12.
- Same stream with rule0 disabled: exactly one `err_o` pulse, `first_err_from_o` 0x28, `first_err_to_o` 0x00, `err_cnt_o` 1.
- PCs 0x10 then 0x80 with `redirect_i` high on the 0x80 sample: no error; a following 0x88 gives an error with first_err 0x80→0x88.
- `budget_i` = 5 with 8 sequential samples: `done_o` rises the cycle after the 5th sample; `sample_cnt_o` is held at 5; samples 6–8 are ignored.
- PC 0xFFFFFFFC then 0x00000000: no error (wrap). Then `clear_i` coincident with a sample: counters 0, state IDLE, sample dropped.
- `rst` asserted mid-run after 3 errors: the next cycle shows all outputs at reset values; after release, the previous whitelist transition now errors because its rule was cleared.
